// File: rtl/uart_mem_controller.sv
// uart_mem_controller: UART command parser that reads, bursts and writes a
// DATA_W-wide register file and streams read words MSB-byte-first to uart_tx.
// Optional feature macro: UART_MEM_ACK_EN (0xAA after each write, 0xEE after
// each error). Without the macro the transmitter carries read data only.
module uart_mem_controller #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DATA_LENGTH = 25,
  parameter int RD_LAT      = 1,
  parameter int RX_TIMEOUT  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_data_rx,
  input  logic [7:0]        data_rx,
  input  logic              busy,
  output logic              new_data_tx,
  output logic [7:0]        data_tx,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              drop,
  output logic [7:0]        debug,
  output logic              err
);

  localparam int NB    = DATA_W / 8;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int CL_W  = $clog2(DATA_LENGTH + 1);
  localparam int CNT_W = (CL_W > 8) ? CL_W : 8;
  localparam int TO_W  = $clog2(RX_TIMEOUT + 1);
  localparam int LAT_W = 2;

  localparam logic [7:0] CMD_READ  = 8'h04;
  localparam logic [7:0] CMD_FULL  = 8'h05;
  localparam logic [7:0] CMD_WRITE = 8'h06;
  localparam logic [7:0] CMD_RANGE = 8'h07;
  localparam logic [7:0] CMD_DROP  = 8'h42;

  // Acknowledge bytes sit in the top byte so they leave through the normal shifter
  localparam logic [DATA_W-1:0] ACK_WR_WORD  = DATA_W'(8'hAA) << (DATA_W - 8);
  localparam logic [DATA_W-1:0] ACK_ERR_WORD = DATA_W'(8'hEE) << (DATA_W - 8);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_ADDR, S_GET_COUNT, S_GET_WDATA, S_RD_ADDR,
    S_RD_WAIT, S_SEND_BYTE, S_GUARD, S_WRITE, S_ERR_ACK
  } state_t;

`ifdef UART_MEM_ACK_EN
  localparam state_t S_ERR_DST = S_ERR_ACK;
`else
  localparam state_t S_ERR_DST = S_IDLE;
`endif

  state_t              r_state, w_next;
  logic [7:0]          r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [LAT_W-1:0]    r_wait;
  logic [BC_W-1:0]     r_bcnt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_wdata;
  logic [TO_W-1:0]     r_to;
  logic                r_drop, r_err, r_ack;
  logic [7:0]          r_debug;

  logic w_arg, w_to_exp, w_last_byte;
  logic w_ld_cmd, w_ld_addr, w_set_one, w_ld_cnt, w_full, w_tgl, w_wbyte;
  logic w_cap, w_shift, w_next_word, w_last_word, w_err_ev, w_tx;
  logic w_ack_aa, w_ack_ee, w_ack_done;

  assign w_arg       = (r_state == S_GET_ADDR) || (r_state == S_GET_COUNT) ||
                       (r_state == S_GET_WDATA);
  assign w_to_exp    = w_arg && (r_to == TO_W'(RX_TIMEOUT - 1));
  assign w_last_byte = (r_bcnt == BC_W'(NB - 1));

  assign new_data_tx = w_tx;
  assign data_tx     = r_shift[DATA_W-1 -: 8];
  assign addr        = r_addr;
  assign wr_en       = (r_state == S_WRITE);
  assign wr_data     = r_wdata;
  assign drop        = r_drop;
  assign debug       = r_debug;
  assign err         = r_err;

  // State register; reset abandons whatever transfer is in flight
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and one-cycle action strobes for the datapath
  always_comb begin
    w_next      = r_state;
    w_ld_cmd    = 1'b0;
    w_ld_addr   = 1'b0;
    w_set_one   = 1'b0;
    w_ld_cnt    = 1'b0;
    w_full      = 1'b0;
    w_tgl       = 1'b0;
    w_wbyte     = 1'b0;
    w_cap       = 1'b0;
    w_shift     = 1'b0;
    w_next_word = 1'b0;
    w_last_word = 1'b0;
    w_err_ev    = 1'b0;
    w_tx        = 1'b0;
    w_ack_aa    = 1'b0;
    w_ack_ee    = 1'b0;
    w_ack_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (new_data_rx) begin
          case (data_rx)
            CMD_READ, CMD_WRITE, CMD_RANGE: begin
              w_ld_cmd = 1'b1;
              w_next   = S_GET_ADDR;
            end
            CMD_FULL: begin
              w_full = 1'b1;
              w_next = S_RD_ADDR;
            end
            CMD_DROP: w_tgl = 1'b1;
            default: begin
              w_err_ev = 1'b1;
              w_next   = S_ERR_DST;
            end
          endcase
        end
      end
      S_GET_ADDR: begin
        if (new_data_rx) begin
          w_ld_addr = 1'b1;
          if (r_cmd == CMD_READ) begin
            w_set_one = 1'b1;
            w_next    = S_RD_ADDR;
          end else if (r_cmd == CMD_WRITE) begin
            w_next = S_GET_WDATA;
          end else begin
            w_next = S_GET_COUNT;
          end
        end else if (w_to_exp) begin
          w_err_ev = 1'b1;
          w_next   = S_ERR_DST;
        end
      end
      S_GET_COUNT: begin
        if (new_data_rx) begin
          w_ld_cnt = 1'b1;
          w_next   = (data_rx == 8'h00) ? S_IDLE : S_RD_ADDR;
        end else if (w_to_exp) begin
          w_err_ev = 1'b1;
          w_next   = S_ERR_DST;
        end
      end
      S_GET_WDATA: begin
        if (new_data_rx) begin
          w_wbyte = 1'b1;
          if (w_last_byte) w_next = S_WRITE;
        end else if (w_to_exp) begin
          w_err_ev = 1'b1;
          w_next   = S_ERR_DST;
        end
      end
      S_RD_ADDR: w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (r_wait == LAT_W'(RD_LAT - 1)) begin
          w_cap  = 1'b1;
          w_next = S_SEND_BYTE;
        end
      end
      S_SEND_BYTE: begin
        if (!busy) begin
          w_tx   = 1'b1;
          w_next = S_GUARD;
        end
      end
      S_GUARD: begin
        if (r_ack) begin
          w_ack_done = 1'b1;
          w_next     = S_IDLE;
        end else if (!w_last_byte) begin
          w_shift = 1'b1;
          w_next  = S_SEND_BYTE;
        end else if (r_cnt != CNT_W'(1)) begin
          w_next_word = 1'b1;
          w_next      = S_RD_ADDR;
        end else begin
          w_last_word = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_WRITE: begin
`ifdef UART_MEM_ACK_EN
        w_ack_aa = 1'b1;
        w_next   = S_SEND_BYTE;
`else
        w_next   = S_IDLE;
`endif
      end
      S_ERR_ACK: begin
        w_ack_ee = 1'b1;
        w_next   = S_SEND_BYTE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: argument capture, counters, word shifter and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cmd   <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_wdata <= '0;
      r_to    <= '0;
      r_drop  <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
      r_debug <= '0;
    end else begin
      r_err <= w_err_ev;
      if (new_data_rx) r_debug <= data_rx;
      if (w_ld_cmd)    r_cmd   <= data_rx;
      if (w_tgl)       r_drop  <= ~r_drop;

      if (w_ld_addr)          r_addr <= data_rx[ADDR_W-1:0];
      else if (w_full || w_tgl) r_addr <= '0;
      else if (w_next_word)   r_addr <= r_addr + ADDR_W'(1);

      if (w_full)                          r_cnt <= CNT_W'(DATA_LENGTH);
      else if (w_set_one)                  r_cnt <= CNT_W'(1);
      else if (w_ld_cnt)                   r_cnt <= CNT_W'(data_rx);
      else if (w_next_word || w_last_word) r_cnt <= r_cnt - CNT_W'(1);

      // Idle time between argument bytes; cleared by every byte and outside argument states
      if (w_arg && !new_data_rx) r_to <= r_to + TO_W'(1);
      else                       r_to <= '0;

      if (r_state == S_RD_WAIT) r_wait <= r_wait + LAT_W'(1);
      else                      r_wait <= '0;

      if (w_ld_addr || w_cap || w_ack_aa || w_ack_ee) r_bcnt <= '0;
      else if (w_wbyte || w_shift)                    r_bcnt <= r_bcnt + BC_W'(1);

      if (w_wbyte) r_wdata <= DATA_W'({r_wdata, data_rx});

      // Shifter top byte is data_tx, so it holds after the last byte goes out
      if (w_cap)         r_shift <= rd_data;
      else if (w_shift)  r_shift <= r_shift << 8;
      else if (w_ack_aa) r_shift <= ACK_WR_WORD;
      else if (w_ack_ee) r_shift <= ACK_ERR_WORD;

      if (w_ack_aa || w_ack_ee) r_ack <= 1'b1;
      else if (w_ack_done)      r_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mem_controller.sv
// Bench for uart_mem_controller: randomized command traffic compared with a
// word-level memory/command model; honours UART_MEM_ACK_EN when defined.
`timescale 1ns/1ps
module tb_uart_mem_controller;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 8;
  localparam int DATA_LENGTH = 25;
  localparam int RD_LAT      = 2;
  localparam int RX_TIMEOUT  = 40;
  localparam int NB          = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              new_data_rx;
  logic [7:0]        data_rx;
  logic              busy;
  logic              new_data_tx;
  logic [7:0]        data_tx;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              drop;
  logic [7:0]        debug;
  logic              err;

  uart_mem_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DATA_LENGTH(DATA_LENGTH),
    .RD_LAT(RD_LAT), .RX_TIMEOUT(RX_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .new_data_rx(new_data_rx), .data_rx(data_rx),
    .busy(busy), .new_data_tx(new_data_tx), .data_tx(data_tx), .addr(addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_data(wr_data), .drop(drop),
    .debug(debug), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, b ^ 8'h5A};
  endfunction

  // Register file seen by the DUT, with RD_LAT cycles of read latency
  logic              mem_init;
  logic [DATA_W-1:0] phys [256];
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) phys[i] <= init_word(i);
    end else if (wr_en) begin
      phys[addr] <= wr_data;
    end
    pipe[0] <= phys[addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = pipe[RD_LAT-1];

  // Output monitor, sampled on the falling edge
  logic [7:0]        got_q [$];
  int                tx_edge_q [$];
  int                busy_viol = 0;
  int                n_wr = 0;
  int                n_err = 0;
  logic [ADDR_W-1:0] wr_addr_seen = '0;
  logic [DATA_W-1:0] wr_data_seen = '0;
  always @(negedge clk) begin
    if (new_data_tx) begin
      got_q.push_back(data_tx);
      tx_edge_q.push_back(cyc + 1);
      if (busy) busy_viol = busy_viol + 1;
    end
    if (wr_en) begin
      n_wr = n_wr + 1;
      wr_addr_seen = addr;
      wr_data_seen = wr_data;
    end
    if (err) n_err = n_err + 1;
  end

  // Transmitter model: busy rises the cycle after each strobe
  int busy_len = 0;
  int busy_max = 0;
  bit busy_rand = 1'b0;
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (new_data_tx) begin
        int n;
        n = busy_rand ? int'($urandom_range(busy_max, 0)) : busy_len;
        if (n > 0) begin
          @(posedge clk);
          #1 busy = 1'b1;
          repeat (n) @(posedge clk);
          #1 busy = 1'b0;
        end
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int rd_ptr = 0;
  int last_rx_edge = 0;
  logic [7:0]        exp_q [$];
  logic [DATA_W-1:0] ref_mem [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    @(negedge clk);
    data_rx = b;
    new_data_rx = 1'b1;
    last_rx_edge = cyc + 1;
    @(negedge clk);
    new_data_rx = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    for (int k = NB - 1; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic push_err_ack();
`ifdef UART_MEM_ACK_EN
    exp_q.push_back(8'hEE);
`endif
  endtask

  // Waits for the predicted bytes (bounded), lets the line settle, then compares
  task automatic expect_bytes(input string tag, input int budget);
    int waited;
    int want;
    waited = 0;
    want = exp_q.size();
    while ((got_q.size() - rd_ptr) < want && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    repeat (40) @(negedge clk);
    check({tag, "_count"}, 64'(got_q.size() - rd_ptr), 64'(want));
    for (int k = 0; k < want; k++) begin
      if (rd_ptr + k < got_q.size()) check(tag, 64'(got_q[rd_ptr + k]), 64'(exp_q[k]));
    end
    rd_ptr = got_q.size();
    exp_q.delete();
  endtask

  task automatic do_read(input logic [7:0] a);
    send_rx(8'h04, 0);
    send_rx(a, 0);
    push_word(ref_mem[a]);
    expect_bytes("read", 3000);
  endtask

  task automatic do_range(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] ai;
    send_rx(8'h07, 0);
    send_rx(a, 1);
    send_rx(c, 0);
    for (int j = 0; j < int'(c); j++) begin
      ai = a + j[7:0];
      push_word(ref_mem[ai]);
    end
    expect_bytes("range", 6000);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [DATA_W-1:0] d);
    int w0;
    w0 = n_wr;
    send_rx(8'h06, 0);
    send_rx(a, 2);
    for (int k = NB - 1; k >= 0; k--) send_rx(d[8*k +: 8], 0);
    repeat (4) @(negedge clk);
    check("wr_pulses", 64'(n_wr - w0), 64'd1);
    check("wr_addr", 64'(wr_addr_seen), 64'(a));
    check("wr_data", 64'(wr_data_seen), 64'(d));
    ref_mem[a] = d;
`ifdef UART_MEM_ACK_EN
    exp_q.push_back(8'hAA);
`endif
    expect_bytes("wr_ack", 500);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int e0;
    logic [7:0]        ra;
    logic [DATA_W-1:0] rd;

    rst = 1'b0;
    new_data_rx = 1'b0;
    data_rx = 8'h00;
    mem_init = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    check("rst_new_data_tx", 64'(new_data_tx), 64'd0);
    check("rst_data_tx", 64'(data_tx), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_debug", 64'(debug), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single read with idle transmitter, including first-byte latency
    busy_len = 0;
    base = got_q.size();
    send_rx(8'h04, 0);
    send_rx(8'h07, 0);
    e0 = last_rx_edge;
    push_word(ref_mem[7]);
    expect_bytes("single_read", 500);
    if (tx_edge_q.size() > base) check("read_latency", 64'(tx_edge_q[base] - e0), 64'(2 + RD_LAT));
    check("read_addr", 64'(addr), 64'h07);

    // Legacy full burst with a slow transmitter
    busy_len = 10;
    send_rx(8'h05, 0);
    for (int j = 0; j < DATA_LENGTH; j++) push_word(ref_mem[j]);
    expect_bytes("full_burst", 5000);
    check("full_burst_last_addr", 64'(addr), 64'(DATA_LENGTH - 1));
    busy_len = 0;

    // Addressed write then read-back
    do_write(8'h03, 16'hBEEF);
    do_read(8'h03);

    // Ranged burst wrapping the address space, and a zero-length burst
    do_range(8'hFE, 8'h04);
    check("wrap_last_addr", 64'(addr), 64'h01);
    do_range(8'h10, 8'h00);

    // Argument timeout, then a gap just inside the limit
    e0 = n_err;
    send_rx(8'h04, RX_TIMEOUT + 10);
    check("timeout_err", 64'(n_err - e0), 64'd1);
    push_err_ack();
    expect_bytes("timeout_tx", 500);
    e0 = n_err;
    send_rx(8'h04, RX_TIMEOUT - 6);
    send_rx(8'h21, 0);
    push_word(ref_mem[8'h21]);
    expect_bytes("near_timeout_read", 500);
    check("near_timeout_no_err", 64'(n_err - e0), 64'd0);

    // Unknown command and drop toggling
    e0 = n_err;
    send_rx(8'h99, 3);
    check("bad_cmd_err", 64'(n_err - e0), 64'd1);
    push_err_ack();
    expect_bytes("bad_cmd_tx", 500);
    send_rx(8'h42, 2);
    check("drop_first", 64'(drop), 64'd1);
    check("drop_addr", 64'(addr), 64'd0);
    check("debug_last", 64'(debug), 64'h42);
    send_rx(8'h42, 2);
    check("drop_second", 64'(drop), 64'd0);

    // Randomized command mix against the word-level model
    busy_rand = 1'b1;
    busy_max = 6;
    for (int it = 0; it < 40; it++) begin
      ra = 8'($urandom);
      case ($urandom_range(2, 0))
        0: do_read(ra);
        1: begin
          rd = DATA_W'($urandom);
          do_write(ra, rd);
        end
        default: do_range(ra, 8'($urandom_range(4, 0)));
      endcase
    end
    check("debug_after_random", 64'(debug), 64'(data_rx));
    busy_rand = 1'b0;

    // Reset in the middle of a burst
    busy_len = 3;
    send_rx(8'h42, 0);
    send_rx(8'h05, 30);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_new_data_tx", 64'(new_data_tx), 64'd0);
    check("mid_rst_data_tx", 64'(data_tx), 64'd0);
    check("mid_rst_addr", 64'(addr), 64'd0);
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data), 64'd0);
    check("mid_rst_drop", 64'(drop), 64'd0);
    check("mid_rst_debug", 64'(debug), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    rd_ptr = got_q.size();
    exp_q.delete();
    base = got_q.size();
    repeat (200) @(negedge clk);
    check("post_rst_silent", 64'(got_q.size() - base), 64'd0);
    rd_ptr = got_q.size();
    busy_len = 0;
    do_read(8'h05);

    check("no_tx_while_busy", 64'(busy_viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
